// File: rtl/serial_sub_pkg.sv
// ============================================================================
// serial_sub_pkg : shared types and defaults for the bit-serial subtractor
// Rev 1.0
// ============================================================================
`default_nettype none

package serial_sub_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

`default_nettype wire

// File: rtl/serial_subtractor_fa.sv
// ============================================================================
// serial_subtractor_fa : 1-bit full adder cell
// Rev 1.0
// ============================================================================
`default_nettype none

module serial_subtractor_fa (
   input  logic x,
   input  logic y,
   input  logic cin,
   output logic cout,
   output logic sum
);

   assign sum  = x ^ y ^ cin;
   assign cout = (x & y) | (x & cin) | (y & cin);

endmodule

`default_nettype wire

// File: rtl/serial_subtractor.sv
// ============================================================================
// serial_subtractor : bit-serial x - y - bin, LSB first, via x + ~y + ~bin
// Rev 1.0
// ============================================================================
`default_nettype none

module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] xs_q, xs_d;
   logic [WIDTH-1:0] ys_q, ys_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             bout_q, bout_d;
   logic             ovf_q, ovf_d;

   logic w_sum;
   logic w_cout;
   logic w_accept;
   logic w_last;

   serial_subtractor_fa u_fa (
      .x    (xs_q[0]),
      .y    (ys_q[0]),
      .cin  (carry_q),
      .cout (w_cout),
      .sum  (w_sum)
   );

   assign w_accept = start && (state_q == IDLE || state_q == DONE);
   assign w_last   = (state_q == SHIFT) && (cnt_q == C_CNT_LAST);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (w_accept) state_d = SHIFT;
         SHIFT:   if (w_last)   state_d = DONE;
         DONE:    state_d = w_accept ? SHIFT : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      busy = (state_q == SHIFT);
      done = (state_q == DONE);
   end

   // Datapath next state; the carry into the MSB is carry_q on the last bit
   always_comb begin
      xs_d    = xs_q;
      ys_d    = ys_q;
      diff_d  = diff_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      bout_d  = bout_q;
      ovf_d   = ovf_q;
      if (w_accept) begin
         xs_d    = x;
         ys_d    = ~y;
         carry_d = ~bin;
         cnt_d   = '0;
      end else if (state_q == SHIFT) begin
         xs_d    = xs_q >> 1;
         ys_d    = ys_q >> 1;
         diff_d  = {w_sum, diff_q[WIDTH-1:1]};
         carry_d = w_cout;
         if (w_last) begin
            bout_d = ~w_cout;
            ovf_d  = carry_q ^ w_cout;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         xs_q    <= '0;
         ys_q    <= '0;
         diff_q  <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         bout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         xs_q    <= xs_d;
         ys_q    <= ys_d;
         diff_q  <= diff_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         bout_q  <= bout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign diff = diff_q;
   assign bout = bout_q;
   assign ovf  = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// ============================================================================
// tb_serial_subtractor : directed table, handshake corner cases, random sweep
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_serial_subtractor;

   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [W-1:0] x;
   logic [W-1:0] y;
   logic         bin;
   logic         busy;
   logic         done;
   logic [W-1:0] diff;
   logic         bout;
   logic         ovf;

   int checks   = 0;
   int failures = 0;
   int overlap  = 0;
   int busy_cnt;
   int lat;

   typedef struct {
      logic [7:0] x;
      logic [7:0] y;
      logic       bin;
      logic [7:0] d;
      logic       bo;
      logic       ov;
   } vec_t;

   vec_t vecs[8];

   serial_subtractor #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .x     (x),
      .y     (y),
      .bin   (bin),
      .busy  (busy),
      .done  (done),
      .diff  (diff),
      .bout  (bout),
      .ovf   (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) if (busy && done) overlap++;

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge just after the accepting edge.
   task automatic launch(input logic [7:0] a, input logic [7:0] b, input logic bi);
      x = a; y = b; bin = bi; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Returns at the negedge where done is observed (or after a timeout).
   task automatic wait_done(input string name);
      busy_cnt = 0;
      lat = 0;
      while (!done && lat < 40) begin
         if (busy) busy_cnt++;
         @(negedge clk);
         lat++;
      end
      if (!done) chk({name, "_timeout"}, 0, 1);
   endtask

   task automatic no_done_for(input string name, input int n);
      int seen = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (done) seen++;
      end
      chk(name, seen, 0);
   endtask

   task automatic model(input logic [7:0] a, input logic [7:0] b, input logic bi,
                        output logic [7:0] d, output logic bo, output logic ov);
      int u;
      int s;
      u  = int'(a) - int'(b) - int'(bi);
      s  = int'($signed(a)) - int'($signed(b)) - int'(bi);
      d  = u[7:0];
      bo = (u < 0);
      ov = (s > 127) || (s < -128);
   endtask

   initial begin
      logic [7:0] ra, rb, md;
      logic       rbi, mbo, mov;
      int         rnd_bad;

      vecs[0] = '{8'h50, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0};
      vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
      vecs[2] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
      vecs[3] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
      vecs[4] = '{8'h10, 8'h10, 1'b1, 8'hFF, 1'b1, 1'b0};
      vecs[5] = '{8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0};
      vecs[6] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
      vecs[7] = '{8'h7F, 8'h80, 1'b0, 8'hFF, 1'b1, 1'b1};

      rst_n = 1'b0; start = 1'b0; x = '0; y = '0; bin = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_diff", diff, 0);
      chk("rst_bout", bout, 0);
      chk("rst_ovf",  ovf,  0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 8; i++) begin
         launch(vecs[i].x, vecs[i].y, vecs[i].bin);
         wait_done($sformatf("vec%0d", i));
         chk($sformatf("vec%0d_busy_cycles", i), busy_cnt, W);
         chk($sformatf("vec%0d_latency", i), lat, W);
         chk($sformatf("vec%0d_diff", i), diff, vecs[i].d);
         chk($sformatf("vec%0d_bout", i), bout, vecs[i].bo);
         chk($sformatf("vec%0d_ovf", i), ovf, vecs[i].ov);
         @(negedge clk);
         chk($sformatf("vec%0d_done_pulse", i), done, 0);
         chk($sformatf("vec%0d_hold_diff", i), diff, vecs[i].d);
      end

      // Back-to-back: new start issued during the DONE cycle
      launch(8'h10, 8'h10, 1'b1);
      wait_done("b2b_first");
      chk("b2b_first_diff", diff, 8'hFF);
      launch(8'h03, 8'h01, 1'b0);
      chk("b2b_busy", busy, 1);
      chk("b2b_done_low", done, 0);
      wait_done("b2b_second");
      chk("b2b_second_lat", lat, W);
      chk("b2b_second_diff", diff, 8'h02);
      chk("b2b_second_bout", bout, 0);
      @(negedge clk);

      // start during the 4th SHIFT cycle must be ignored
      launch(8'h50, 8'h20, 1'b0);
      repeat (3) @(negedge clk);
      x = 8'hAA; y = 8'h11; bin = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done("ign");
      chk("ign_lat", lat, W - 4);
      chk("ign_diff", diff, 8'h30);
      chk("ign_bout", bout, 0);
      no_done_for("ign_single_done", 2 * W);
      chk("ign_idle", busy, 0);

      // Reset asserted during the 5th SHIFT cycle
      launch(8'h80, 8'h01, 1'b0);
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_diff", diff, 0);
      chk("abort_ovf",  ovf,  0);
      @(negedge clk);
      rst_n = 1'b1;
      no_done_for("abort_no_done", 2 * W);
      launch(8'h80, 8'h01, 1'b0);
      wait_done("abort_fresh");
      chk("abort_fresh_diff", diff, 8'h7F);
      chk("abort_fresh_ovf",  ovf,  1);
      @(negedge clk);

      // Randomized sweep against an integer model
      rnd_bad = 0;
      for (int i = 0; i < 1000; i++) begin
         ra  = 8'($urandom_range(0, 255));
         rb  = 8'($urandom_range(0, 255));
         rbi = 1'($urandom_range(0, 1));
         model(ra, rb, rbi, md, mbo, mov);
         launch(ra, rb, rbi);
         wait_done("rnd");
         checks++;
         if (diff !== md || bout !== mbo || ovf !== mov) begin
            failures++;
            if (rnd_bad < 5)
               $display("FAIL rnd x=%02h y=%02h bin=%0b: got diff=%02h bout=%0b ovf=%0b expected diff=%02h bout=%0b ovf=%0b",
                        ra, rb, rbi, diff, bout, ovf, md, mbo, mov);
            rnd_bad++;
         end
         @(negedge clk);
      end

      chk("busy_done_overlap", overlap, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
